// File: rtl/iomem_word_bridge_pkg.sv
// Shared types and helpers for the iomem line-to-word bridge.
// Beat selection is expressed over a generic active-beat vector so reads and masked writes share one search.
package iomem_word_bridge_pkg;

   localparam int BLK_SIZE_DEF = 128;
   localparam int BLK_WORDS    = BLK_SIZE_DEF / 32;
   localparam int MAX_BEATS    = 64;
   localparam int BEAT_IDX_W   = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_RESP
   } bridge_state_e;

   typedef struct packed {
      logic                  found;
      logic [BEAT_IDX_W-1:0] idx;
   } beat_sel_t;

   // Lowest active beat at or above start; scanning downwards lets the lowest match win.
   function automatic beat_sel_t next_active_beat(input logic [MAX_BEATS-1:0] act,
                                                  input int                   start);
      beat_sel_t sel;
      sel = '0;
      for (int i = MAX_BEATS - 1; i >= 0; i--) begin
         if (i >= start && act[i]) begin
            sel.found = 1'b1;
            sel.idx   = i[BEAT_IDX_W-1:0];
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/iomem_word_bridge.sv
// Splits one cache-line request into 32-bit word transactions on a req/gnt/rvalid port
// and returns a single-cycle line response. One line and one word outstanding at a time.
module iomem_word_bridge
   import iomem_word_bridge_pkg::*;
#(
   parameter int BLK_SIZE = BLK_WORDS * 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  iomem_req_valid_i,
   input  logic [31:0]           iomem_req_addr_i,
   input  logic [BLK_SIZE-1:0]   iomem_req_data_i,
   input  logic [BLK_SIZE/8-1:0] iomem_req_rw_i,
   output logic                  iomem_res_valid_o,
   output logic [BLK_SIZE-1:0]   iomem_res_data_o,
   output logic                  mem_req_o,
   input  logic                  mem_gnt_i,
   output logic [31:0]           mem_addr_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [31:0]           mem_wdata_o,
   input  logic                  mem_rvalid_i,
   input  logic [31:0]           mem_rdata_i
);

   localparam int NBEATS = BLK_SIZE / 32;
   localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int MASK_W = BLK_SIZE / 8;
   localparam int OFF_W  = $clog2(MASK_W);
   localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);

   bridge_state_e         r_state;
   logic [31:0]           r_base;
   logic [BLK_SIZE-1:0]   r_wdata;
   logic [MASK_W-1:0]     r_mask;
   logic                  r_is_write;
   logic [BEAT_W-1:0]     r_beat;
   logic [BLK_SIZE-1:0]   r_line;
   logic                  r_res_valid;
   logic [BLK_SIZE-1:0]   r_res_data;
   logic                  r_mem_req;
   logic [31:0]           r_mem_addr;
   logic                  r_mem_we;
   logic [3:0]            r_mem_be;
   logic [31:0]           r_mem_wdata;

   logic [31:0]           w_src_base;
   logic [BLK_SIZE-1:0]   w_src_data;
   logic [MASK_W-1:0]     w_src_mask;
   logic                  w_src_wr;
   logic [MAX_BEATS-1:0]  w_act;
   beat_sel_t             w_next;
   logic [31:0]           w_addr;
   logic [3:0]            w_be;
   logic [31:0]           w_wdata;
   logic [BLK_SIZE-1:0]   w_line;

   // In IDLE the first beat is computed straight from the incoming request so REQ starts with valid outputs.
   always_comb begin
      if (r_state == ST_IDLE) begin
         w_src_base = iomem_req_addr_i & LINE_MASK;
         w_src_data = iomem_req_data_i;
         w_src_mask = iomem_req_rw_i;
      end else begin
         w_src_base = r_base;
         w_src_data = r_wdata;
         w_src_mask = r_mask;
      end
      w_src_wr = |w_src_mask;

      w_act = '0;
      for (int b = 0; b < NBEATS; b++) begin
         w_act[b] = w_src_wr ? (|w_src_mask[4*b +: 4]) : 1'b1;
      end
      w_next = next_active_beat(w_act, (r_state == ST_IDLE) ? 0 : int'(r_beat) + 1);

      w_addr  = w_src_base + (32'(w_next.idx) << 2);
      w_be    = w_src_wr ? w_src_mask[4*w_next.idx +: 4] : 4'hF;
      w_wdata = w_src_data[32*w_next.idx +: 32];

      w_line = r_line;
      w_line[32*r_beat +: 32] = mem_rdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_base      <= '0;
         r_wdata     <= '0;
         r_mask      <= '0;
         r_is_write  <= 1'b0;
         r_beat      <= '0;
         r_line      <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (iomem_req_valid_i) begin
                  r_base      <= w_src_base;
                  r_wdata     <= iomem_req_data_i;
                  r_mask      <= iomem_req_rw_i;
                  r_is_write  <= w_src_wr;
                  r_beat      <= w_next.idx[BEAT_W-1:0];
                  r_mem_req   <= 1'b1;
                  r_mem_addr  <= w_addr;
                  r_mem_we    <= w_src_wr;
                  r_mem_be    <= w_be;
                  r_mem_wdata <= w_wdata;
                  r_state     <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem_gnt_i) begin
                  r_mem_req <= 1'b0;
                  r_state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid_i) begin
                  if (!r_is_write) begin
                     r_line <= w_line;
                  end
                  if (w_next.found) begin
                     r_beat      <= w_next.idx[BEAT_W-1:0];
                     r_mem_req   <= 1'b1;
                     r_mem_addr  <= w_addr;
                     r_mem_we    <= w_src_wr;
                     r_mem_be    <= w_be;
                     r_mem_wdata <= w_wdata;
                     r_state     <= ST_REQ;
                  end else begin
                     r_res_valid <= 1'b1;
                     r_res_data  <= r_is_write ? r_wdata : w_line;
                     r_state     <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               r_res_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign iomem_res_valid_o = r_res_valid;
   assign iomem_res_data_o  = r_res_data;
   assign mem_req_o         = r_mem_req;
   assign mem_addr_o        = r_mem_addr;
   assign mem_we_o          = r_mem_we;
   assign mem_be_o          = r_mem_be;
   assign mem_wdata_o       = r_mem_wdata;

endmodule

// File: tb/tb_iomem_word_bridge.sv
// Bench for iomem_word_bridge: directed scenarios plus randomized lines against a line-level model.
module tb_iomem_word_bridge;

   localparam int BLK = 128;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             iomem_req_valid_i;
   logic [31:0]      iomem_req_addr_i;
   logic [BLK-1:0]   iomem_req_data_i;
   logic [BLK/8-1:0] iomem_req_rw_i;
   logic             iomem_res_valid_o;
   logic [BLK-1:0]   iomem_res_data_o;
   logic             mem_req_o;
   logic             mem_gnt_i;
   logic [31:0]      mem_addr_o;
   logic             mem_we_o;
   logic [3:0]       mem_be_o;
   logic [31:0]      mem_wdata_o;
   logic             mem_rvalid_i;
   logic [31:0]      mem_rdata_i;

   always #5 clk_i = ~clk_i;

   iomem_word_bridge #(.BLK_SIZE(BLK)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .iomem_req_valid_i (iomem_req_valid_i),
      .iomem_req_addr_i  (iomem_req_addr_i),
      .iomem_req_data_i  (iomem_req_data_i),
      .iomem_req_rw_i    (iomem_req_rw_i),
      .iomem_res_valid_o (iomem_res_valid_o),
      .iomem_res_data_o  (iomem_res_data_o),
      .mem_req_o         (mem_req_o),
      .mem_gnt_i         (mem_gnt_i),
      .mem_addr_o        (mem_addr_o),
      .mem_we_o          (mem_we_o),
      .mem_be_o          (mem_be_o),
      .mem_wdata_o       (mem_wdata_o),
      .mem_rvalid_i      (mem_rvalid_i),
      .mem_rdata_i       (mem_rdata_i)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] key   = 32'h0;
   bit          rnd_dly = 1'b0;
   int          gnt_tab[$];
   int          rv_tab[$];
   logic [68:0] bus_log[$];
   logic [68:0] exp_q[$];
   logic [127:0] exp_res;
   logic [127:0] got_res;
   int          exp_lat;
   int          pulses = 0;
   int          exp_pulses = 0;
   int          unstable = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory responder: grants after a per-beat delay, answers every accepted word with rdata = addr ^ key.
   initial begin
      bit          active;
      bit          pending;
      int          cnt;
      int          tgt;
      int          rcnt;
      logic [68:0] cap;
      logic [31:0] paddr;
      active = 0; pending = 0; cnt = 0; tgt = 0; rcnt = 0; cap = '0; paddr = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      forever begin
         @(posedge clk_i); #1;
         mem_rvalid_i = 1'b0;
         if (mem_gnt_i) begin
            mem_gnt_i = 1'b0;
            bus_log.push_back(cap);
            pending = 1;
            paddr = cap[68:37];
            rcnt = (rv_tab.size() > 0) ? rv_tab.pop_front() : (rnd_dly ? int'($urandom_range(0, 2)) : 0);
         end
         if (pending) begin
            if (rcnt == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = paddr ^ key;
               pending = 0;
            end else begin
               rcnt--;
            end
         end else if (mem_req_o) begin
            if (!active) begin
               active = 1;
               cnt = 0;
               tgt = (gnt_tab.size() > 0) ? gnt_tab.pop_front() : (rnd_dly ? int'($urandom_range(0, 2)) : 0);
               cap = {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o};
            end else if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== cap) begin
               unstable++;
            end
            if (cnt == tgt) begin
               mem_gnt_i = 1'b1;
               active = 0;
            end else begin
               cnt++;
            end
         end else begin
            active = 0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk_i); #1;
         if (iomem_res_valid_o) pulses++;
      end
   end

   // Line-level reference: which words travel on the bus, what comes back, and zero-wait latency.
   task automatic build_expect(input logic [31:0] addr, input logic [127:0] data, input logic [15:0] mask);
      logic [31:0] base;
      base = addr & 32'hFFFF_FFF0;
      exp_q.delete();
      exp_res = data;
      for (int w = 0; w < 4; w++) begin
         logic [31:0] wa;
         wa = base + 32'(4 * w);
         if (mask == 16'h0) begin
            exp_q.push_back({wa, 1'b0, 4'hF, data[32*w +: 32]});
            exp_res[32*w +: 32] = wa ^ key;
         end else if (mask[4*w +: 4] != 4'h0) begin
            exp_q.push_back({wa, 1'b1, mask[4*w +: 4], data[32*w +: 32]});
         end
      end
      exp_lat = 2 * exp_q.size() + 1;
   endtask

   // Caller is #1 after a rising edge; that cycle is cycle 0 of the request.
   task automatic run_line(input string tag, input logic [31:0] addr, input logic [127:0] data,
                           input logic [15:0] mask, input bit chk_lat);
      int n;
      bit got;
      build_expect(addr, data, mask);
      bus_log.delete();
      iomem_req_valid_i = 1'b1;
      iomem_req_addr_i  = addr;
      iomem_req_data_i  = data;
      iomem_req_rw_i    = mask;
      n = 0; got = 0;
      while (!got && n < 300) begin
         @(posedge clk_i); #1;
         n++;
         if (iomem_res_valid_o) got = 1;
      end
      chk({tag, " done"}, 128'(got), 128'd1);
      got_res = iomem_res_data_o;
      iomem_req_valid_i = 1'b0;
      if (got) begin
         exp_pulses++;
         if (chk_lat) chk({tag, " lat"}, 128'(n), 128'(exp_lat));
         chk({tag, " data"}, got_res, exp_res);
         chk({tag, " nwords"}, 128'(bus_log.size()), 128'(exp_q.size()));
         for (int i = 0; i < exp_q.size() && i < bus_log.size(); i++)
            chk($sformatf("%s word%0d", tag, i), 128'(bus_log[i]), 128'(exp_q[i]));
      end
      @(posedge clk_i); #1;
      chk({tag, " pulse1"}, 128'(iomem_res_valid_o), 128'd0);
   endtask

   function automatic logic [15:0] rand_mask();
      int sel;
      sel = int'($urandom_range(0, 2));
      if (sel == 0) return 16'h0;
      if (sel == 1) return 16'($urandom);
      return 16'(32'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
   endfunction

   initial begin
      int n;
      int p0;
      rst_i = 1'b1;
      iomem_req_valid_i = 1'b0;
      iomem_req_addr_i  = '0;
      iomem_req_data_i  = '0;
      iomem_req_rw_i    = '0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst res_valid", 128'(iomem_res_valid_o), 128'd0);
      chk("rst res_data", iomem_res_data_o, 128'd0);
      chk("rst mem_req", 128'(mem_req_o), 128'd0);
      chk("rst mem_fields", 128'({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}), 128'd0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      run_line("rd0", 32'h8000_0014, {$urandom, $urandom, $urandom, $urandom}, 16'h0, 1);
      chk("rd0 line", got_res, 128'h8000001C_80000018_80000014_80000010);

      run_line("wr1", 32'h0000_0100, {$urandom, $urandom, 32'hDEADBEEF, $urandom}, 16'h00F0, 1);
      if (bus_log.size() > 0)
         chk("wr1 beat", 128'(bus_log[0]), 128'({32'h104, 1'b1, 4'hF, 32'hDEADBEEF}));

      run_line("wr2", 32'h0000_0000, {$urandom, $urandom, $urandom, $urandom}, 16'h3001, 1);

      key = $urandom;
      gnt_tab = '{0, 0, 3, 0};
      rv_tab  = '{0, 0, 2, 0};
      unstable = 0;
      run_line("rdstall", $urandom, {$urandom, $urandom, $urandom, $urandom}, 16'h0, 0);
      chk("rdstall stable", 128'(unstable), 128'd0);

      // Reset while waiting on beat 1's response; that response then arrives stray.
      rv_tab = '{0, 6};
      bus_log.delete();
      p0 = pulses;
      iomem_req_valid_i = 1'b1;
      iomem_req_addr_i  = 32'h0000_2040;
      iomem_req_rw_i    = 16'h0;
      n = 0;
      while (bus_log.size() < 2 && n < 50) begin
         @(posedge clk_i); #1;
         n++;
      end
      chk("rstw reached", 128'(bus_log.size() >= 2), 128'd1);
      rst_i = 1'b1;
      iomem_req_valid_i = 1'b0;
      @(posedge clk_i); #1;
      chk("rstw mem_req", 128'(mem_req_o), 128'd0);
      chk("rstw res", 128'({iomem_res_valid_o, iomem_res_data_o}), 128'd0);
      chk("rstw mem_fields", 128'({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}), 128'd0);
      rst_i = 1'b0;
      repeat (10) begin
         @(posedge clk_i); #1;
      end
      chk("rstw no pulse", 128'(pulses - p0), 128'd0);
      chk("rstw idle", 128'(mem_req_o), 128'd0);
      run_line("rd after rst", 32'h0000_2048, {$urandom, $urandom, $urandom, $urandom}, 16'h0, 1);

      // Back-to-back: each run_line raises valid in the cycle right after the previous RESP.
      run_line("b2b a", $urandom, {$urandom, $urandom, $urandom, $urandom}, 16'hF00F, 1);
      run_line("b2b b", $urandom, {$urandom, $urandom, $urandom, $urandom}, 16'h0, 1);

      for (int i = 0; i < 12; i++)
         run_line($sformatf("rz%0d", i), $urandom, {$urandom, $urandom, $urandom, $urandom}, rand_mask(), 1);
      rnd_dly = 1'b1;
      for (int i = 0; i < 12; i++)
         run_line($sformatf("rd%0d", i), $urandom, {$urandom, $urandom, $urandom, $urandom}, rand_mask(), 0);

      chk("pulse count", 128'(pulses), 128'(exp_pulses));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
